membus_master: RTL

- Initiator end of the PDP-6 memory bus: converts 36-bit Avalon-MM slave transactions into membus read or write cycles on one membus port.
- Used by the console/DMA path to reach any responder on the same port as a processor, e.g. core memory or fast memory.
- Drives rq_cyc, rd_rq/wr_rq, address and select; waits for addr_ack; collects read data until rd_rs, or presents write data and issues wr_rs.
- A no-answer timeout reports non-existent memory (NXM).

---
 rtl/membus_pkg.sv | 41 ++++
 rtl/membus_master_if.sv | 26 ++
 rtl/membus_timeout.sv | 28 ++
 rtl/membus_master.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared PDP-6 memory bus definitions: initiator state encoding, address field
// positions and the Avalon/PDP word bit-order helpers used by initiators and responders.
package membus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RDWAIT,
    WRDATA,
    DONE
  } bus_state_e;

  localparam int WORD_W = 36;
  localparam int ADDR_W = 18;
  localparam int CNT_W  = 16;

  // Avalon address bit n carries PDP address bit 35-n, so PDP fields map to these slices.
  localparam int MA_HI  = 14;
  localparam int MA_LO  = 0;
  localparam int SEL_HI = 17;
  localparam int SEL_LO = 14;
  localparam int FMC_HI = 17;
  localparam int FMC_LO = 4;

  function automatic logic [0:WORD_W-1] avalon_to_pdp(input logic [WORD_W-1:0] w);
    logic [0:WORD_W-1] r;
    for (int i = 0; i < WORD_W; i++) begin
      r[i] = w[WORD_W-1-i];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] pdp_to_avalon(input logic [0:WORD_W-1] p);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) begin
      r[WORD_W-1-i] = p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/membus_master_if.sv
// One PDP-6 membus port, seen from the initiator (master) or a responder (slave).
interface membus_master_if;

  logic          rq_cyc;
  logic          rd_rq;
  logic          wr_rq;
  logic [21:35]  ma;
  logic [18:21]  sel;
  logic          fmc_select;
  logic [0:35]   mb_out;
  logic          wr_rs;
  logic          addr_ack;
  logic          rd_rs;
  logic [0:35]   mb_in;

  modport master (
    output rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_out, wr_rs,
    input  addr_ack, rd_rs, mb_in
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_out, wr_rs,
    output addr_ack, rd_rs, mb_in
  );

endinterface

// File: rtl/membus_timeout.sv
// Saturating phase counter: cleared by load, advanced by enable, flags when it
// has reached the per-phase limit.
module membus_timeout #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/membus_master.sv
// Avalon-MM slave to PDP-6 membus initiator: runs one read or write bus cycle per
// request and flags non-existent memory when the responder never answers.
module membus_master
  import membus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000,
  parameter int RS_TIMEOUT  = 1000,
  parameter int WR_SETUP    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [WORD_W-1:0]   s_writedata,
  output logic [WORD_W-1:0]   s_readdata,
  output logic                s_waitrequest,
  input  logic                fmc_en,
  output logic                nxm,
  input  logic                nxm_clr,
  membus_master_if.master     bus
);

  bus_state_e state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rd_buf;
  logic [WORD_W-1:0] readdata_q;
  logic              read_q;
  logic              fmc_q;
  logic              nxm_q;

  logic              request;
  logic              nxm_set;
  logic              phase_load;
  logic              phase_enable;
  logic              phase_expired;
  logic [CNT_W-1:0]  phase_limit;

  assign request = s_read | s_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Acknowledge beats the timeout when both land in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (request) state_next = REQ;
      end
      REQ: begin
        if (bus.addr_ack)       state_next = read_q ? RDWAIT : WRDATA;
        else if (phase_expired) state_next = DONE;
      end
      RDWAIT: begin
        if (bus.rd_rs || phase_expired) state_next = DONE;
      end
      WRDATA: begin
        if (phase_expired) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.rq_cyc     = 1'b0;
    bus.rd_rq      = 1'b0;
    bus.wr_rq      = 1'b0;
    bus.ma         = '0;
    bus.sel        = '0;
    bus.fmc_select = 1'b0;
    bus.mb_out     = '0;
    bus.wr_rs      = 1'b0;
    s_waitrequest  = 1'b1;
    case (state)
      IDLE: begin
        s_waitrequest = request;
      end
      REQ: begin
        bus.rq_cyc     = 1'b1;
        bus.rd_rq      = read_q;
        bus.wr_rq      = ~read_q;
        bus.ma         = addr_q[MA_HI:MA_LO];
        bus.sel        = addr_q[SEL_HI:SEL_LO];
        bus.fmc_select = fmc_q;
      end
      WRDATA: begin
        bus.mb_out = avalon_to_pdp(data_q);
        bus.wr_rs  = phase_expired;
      end
      DONE: begin
        s_waitrequest = 1'b0;
      end
      default: begin
        s_waitrequest = 1'b1;
      end
    endcase
  end

  // One counter serves every phase; it restarts on each state change.
  always_comb begin
    phase_limit = '1;
    case (state)
      REQ:     phase_limit = CNT_W'(ACK_TIMEOUT);
      RDWAIT:  phase_limit = CNT_W'(RS_TIMEOUT);
      WRDATA:  phase_limit = CNT_W'(WR_SETUP);
      default: phase_limit = '1;
    endcase
  end

  assign phase_load   = (state_next != state);
  assign phase_enable = (state == REQ) || (state == RDWAIT) || (state == WRDATA);

  membus_timeout #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (phase_load),
    .enable  (phase_enable),
    .limit   (phase_limit),
    .expired (phase_expired)
  );

  // Responders strobe read data ahead of rd_rs, so the buffer accumulates every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      read_q     <= 1'b0;
      fmc_q      <= 1'b0;
      rd_buf     <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            addr_q <= s_address;
            data_q <= s_writedata;
            read_q <= s_read;
            fmc_q  <= fmc_en && (s_address[FMC_HI:FMC_LO] == '0);
          end
        end
        REQ: begin
          if (bus.addr_ack) begin
            rd_buf <= '0;
          end else if (phase_expired && read_q) begin
            readdata_q <= '0;
          end
        end
        RDWAIT: begin
          if (bus.rd_rs) begin
            readdata_q <= rd_buf | pdp_to_avalon(bus.mb_in);
          end else if (phase_expired) begin
            readdata_q <= rd_buf;
          end else begin
            rd_buf <= rd_buf | pdp_to_avalon(bus.mb_in);
          end
        end
        default: begin
          rd_buf <= rd_buf;
        end
      endcase
    end
  end

  assign nxm_set = phase_expired &&
                   (((state == REQ) && !bus.addr_ack) || ((state == RDWAIT) && !bus.rd_rs));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nxm_q <= 1'b0;
    end else if (nxm_clr) begin
      nxm_q <= 1'b0;
    end else if (nxm_set) begin
      nxm_q <= 1'b1;
    end
  end

  assign s_readdata = readdata_q;
  assign nxm        = nxm_q;

endmodule
